// File: rtl/char_buf_pkg.sv
// Shared constants and types for the 16x16 character buffer writer.
// The optional cursor blink is enabled by CHAR_BUF_CURSOR_BLINK_EN.
package char_buf_pkg;

   localparam int COLS  = 16;
   localparam int ROWS  = 16;
   localparam int CELLS = COLS * ROWS;

   localparam logic [7:0] CHAR_CR    = 8'h0D;
   localparam logic [7:0] CHAR_LF    = 8'h0A;
   localparam logic [7:0] CHAR_BS    = 8'h08;
   localparam logic [6:0] CHAR_SPACE = 7'h20;

   typedef enum logic {CLEAR, IDLE} char_buf_state_t;

   function automatic logic is_printable(input logic [7:0] c);
      return (c >= 8'h20) && (c <= 8'h7E);
   endfunction

endpackage

// File: rtl/char_buf_writer_16x16_if.sv
// Character stream handshake between a byte source and the buffer writer.
interface char_buf_writer_16x16_if;
   logic [7:0] char_in;
   logic       char_valid;
   logic       char_ready;
   logic       clear_req;

   modport master (
      output char_in,
      output char_valid,
      output clear_req,
      input  char_ready
   );

   modport slave (
      input  char_in,
      input  char_valid,
      input  clear_req,
      output char_ready
   );
endinterface

// File: rtl/char_buf_ram_256x7.sv
// 256x7 character store: synchronous write, asynchronous read.
module char_buf_ram_256x7 (
   input  logic       clk,
   input  logic       we,
   input  logic [7:0] waddr,
   input  logic [6:0] wdata,
   input  logic [7:0] raddr,
   output logic [6:0] rdata
);

   logic [6:0] mem [256];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/char_buf_writer_16x16.sv
// Writer side of the 16x16 text buffer: cursor handling, CR/LF/BS, full clear.
// Defining CHAR_BUF_CURSOR_BLINK_EN adds the cursor_on blink output.
module char_buf_writer_16x16
   import char_buf_pkg::*;
#(
   parameter logic [6:0] CLEAR_CODE   = 7'h20,
   parameter int         BLINK_CYCLES = 20_000_000
) (
   input  logic                      clk,
   input  logic                      rst,
   char_buf_writer_16x16_if.slave    bus,
   input  logic [7:0]                char_xy,
   output logic [6:0]                char_code,
   output logic [3:0]                cursor_x,
   output logic [3:0]                cursor_y,
`ifdef CHAR_BUF_CURSOR_BLINK_EN
   output logic                      cursor_on,
`endif
   output logic                      busy
);

   char_buf_state_t state_reg, state_next;
   logic [7:0]      clr_addr_reg, clr_addr_next;
   // Cursor kept as a linear cell index {row,col}; +1/-1 give the wrap rules for free.
   logic [7:0]      pos_reg, pos_next;
   logic            we;
   logic [7:0]      waddr;
   logic [6:0]      wdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= CLEAR;
         clr_addr_reg <= 8'd0;
         pos_reg      <= 8'd0;
      end else begin
         state_reg    <= state_next;
         clr_addr_reg <= clr_addr_next;
         pos_reg      <= pos_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      clr_addr_next = clr_addr_reg;
      pos_next      = pos_reg;
      we            = 1'b0;
      waddr         = clr_addr_reg;
      wdata         = CLEAR_CODE;
      case (state_reg)
         CLEAR: begin
            we            = 1'b1;
            clr_addr_next = clr_addr_reg + 8'd1;
            if (clr_addr_reg == 8'hFF) begin
               state_next = IDLE;
            end
         end
         IDLE: begin
            if (bus.clear_req) begin
               state_next = CLEAR;
               pos_next   = 8'd0;
            end else if (bus.char_valid) begin
               if (is_printable(bus.char_in)) begin
                  we       = 1'b1;
                  waddr    = pos_reg;
                  wdata    = bus.char_in[6:0];
                  pos_next = pos_reg + 8'd1;
               end else if (bus.char_in == CHAR_CR) begin
                  pos_next = {pos_reg[7:4], 4'h0};
               end else if (bus.char_in == CHAR_LF) begin
                  pos_next = {pos_reg[7:4] + 4'd1, 4'h0};
               end else if (bus.char_in == CHAR_BS && pos_reg != 8'd0) begin
                  pos_next = pos_reg - 8'd1;
                  we       = 1'b1;
                  waddr    = pos_reg - 8'd1;
                  wdata    = CHAR_SPACE;
               end
            end
         end
         default: state_next = CLEAR;
      endcase
   end

   assign bus.char_ready = (state_reg == IDLE) && !bus.clear_req;
   assign busy           = (state_reg == CLEAR);
   assign cursor_x       = pos_reg[3:0];
   assign cursor_y       = pos_reg[7:4];

   char_buf_ram_256x7 u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (char_xy),
      .rdata (char_code)
   );

`ifdef CHAR_BUF_CURSOR_BLINK_EN
   localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

   logic [BW-1:0] blink_cnt_reg;
   logic          cursor_on_reg;
   logic          blink_restart;

   // Any activity that reaches the buffer keeps the cursor solidly visible.
   assign blink_restart = (state_reg == IDLE) && (bus.clear_req || bus.char_valid);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blink_cnt_reg <= '0;
         cursor_on_reg <= 1'b1;
      end else if (blink_restart) begin
         blink_cnt_reg <= '0;
         cursor_on_reg <= 1'b1;
      end else if (blink_cnt_reg == BW'(BLINK_CYCLES - 1)) begin
         blink_cnt_reg <= '0;
         cursor_on_reg <= ~cursor_on_reg;
      end else begin
         blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
   end

   assign cursor_on = cursor_on_reg;
`endif

endmodule
